// File: rtl/fb_write_scheduler_if.sv
// Write-request and frame-buffer-port bundle; master = requester side, slave = scheduler side.
// No storage; ready is a combinational grant, the frame-buffer side is registered by the scheduler.
interface fb_write_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 19,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [ADDR_W-1:0]         fb_wraddress;
    logic [DATA_W-1:0]         fb_data;
    logic                      fb_wren;

    modport master (
        output req_valid, req_addr, req_data,
        input  req_ready, fb_wraddress, fb_data, fb_wren
    );

    modport slave (
        input  req_valid, req_addr, req_data,
        output req_ready, fb_wraddress, fb_data, fb_wren
    );
endinterface

// File: rtl/fb_write_scheduler.sv
// Frame-buffer write-port scheduler: optional clear phase (FB_CLEAR_EN), then round-robin pixel writes.
// Latency: a granted write appears on fb_* one cycle later; clear writes one per cycle.
// Backpressure: req_ready is a one-hot combinational grant; requesters hold valid until granted.
module fb_write_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int FB_DEPTH = 307200,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_start,
    input  logic                draw_end,
    input  logic [DATA_W-1:0]   clear_color,
    fb_write_scheduler_if.slave bus,
    output logic                busy,
    output logic                clearing,
    output logic                overrun,
    output logic                addr_err
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(FB_DEPTH);

`ifdef FB_CLEAR_EN
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_ARB} state_t;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] clr_q;
    logic              clearing_q;
`else
    typedef enum logic {S_IDLE, S_ARB} state_t;
`endif

    state_t            state;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  sel_idx;
    logic [PTR_W-1:0]  cand;
    logic              found;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              wren_q;

    // Search starts at the pointer and wraps; frame_start/draw_end cycles never grant.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        if (state == S_ARB && !frame_start && !draw_end) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = PTR_W'((int'(ptr) + k) % NUM_REQ);
                if (!found && bus.req_valid[cand]) begin
                    found   = 1'b1;
                    sel_idx = cand;
                end
            end
            grant[sel_idx] = found;
        end
    end

    assign sel_addr = bus.req_addr[sel_idx*ADDR_W +: ADDR_W];
    assign sel_data = bus.req_data[sel_idx*DATA_W +: DATA_W];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wren_q    <= 1'b0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
            addr_err  <= 1'b0;
`ifdef FB_CLEAR_EN
            cnt        <= '0;
            clr_q      <= '0;
            clearing_q <= 1'b0;
`endif
        end else begin
            wren_q   <= 1'b0;
            overrun  <= 1'b0;
            addr_err <= 1'b0;
            if (frame_start) begin
                overrun <= (state != S_IDLE);
                busy    <= 1'b1;
`ifdef FB_CLEAR_EN
                // First clear write (address 0) goes out in the cycle CLEAR is entered.
                state      <= S_CLEAR;
                clearing_q <= 1'b1;
                cnt        <= '0;
                clr_q      <= clear_color;
                wren_q     <= 1'b1;
                wr_addr_q  <= '0;
                wr_data_q  <= clear_color;
`else
                state <= S_ARB;
`endif
            end else begin
                case (state)
`ifdef FB_CLEAR_EN
                    S_CLEAR: begin
                        if (cnt == LAST) begin
                            state      <= S_ARB;
                            clearing_q <= 1'b0;
                            cnt        <= '0;
                        end else begin
                            cnt       <= cnt + 1'b1;
                            wren_q    <= 1'b1;
                            wr_addr_q <= cnt + 1'b1;
                            wr_data_q <= clr_q;
                        end
                    end
`endif
                    S_ARB: begin
                        if (draw_end) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else if (found) begin
                            ptr <= (sel_idx == PTR_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
                            if ({1'b0, sel_addr} < DEPTH) begin
                                wren_q    <= 1'b1;
                                wr_addr_q <= sel_addr;
                                wr_data_q <= sel_data;
                            end else begin
                                addr_err <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef FB_CLEAR_EN
    assign clearing = clearing_q;
`else
    logic unused_clear_color;
    assign unused_clear_color = ^clear_color;
    assign clearing = 1'b0;
`endif

    assign bus.req_ready    = grant;
    assign bus.fb_wraddress = wr_addr_q;
    assign bus.fb_data      = wr_data_q;
    assign bus.fb_wren      = wren_q;
endmodule

// File: tb/tb_fb_write_scheduler.sv
// Bench for fb_write_scheduler (NUM_REQ=4, FB_DEPTH=16); follows FB_CLEAR_EN like the design.
// Grants and writes are predicted by a first-valid-from-pointer model over plain ints.
module tb_fb_write_scheduler;
    localparam int NR    = 4;
    localparam int AW    = 19;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          Clk;
    logic          Reset_n     = 1'b1;
    logic          frame_start = 1'b0;
    logic          draw_end    = 1'b0;
    logic [DW-1:0] clear_color = '0;
    logic          busy, clearing, overrun, addr_err;

    int checks = 0;
    int errors = 0;
    int mptr   = 0;

    fb_write_scheduler_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_write_scheduler #(.NUM_REQ(NR), .FB_DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .frame_start (frame_start),
        .draw_end    (draw_end),
        .clear_color (clear_color),
        .bus         (bus),
        .busy        (busy),
        .clearing    (clearing),
        .overrun     (overrun),
        .addr_err    (addr_err)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int p);
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (p + k) % NR;
            if (v[2'(j)]) return j;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] oh(input int g);
        logic [NR-1:0] r;
        r = '0;
        if (g >= 0) r[2'(g)] = 1'b1;
        return r;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]           = v;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_data[i*DW +: DW]   = d;
    endtask

    // Starts a frame and waits (bounded) until the scheduler is arbitrating.
    task automatic enter_arb;
        bus.req_valid = '0;
        frame_start   = 1'b1;
        tick();
        frame_start   = 1'b0;
        for (int n = 0; n < 100 && clearing; n++) tick();
        checks++;
        if (clearing !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL enter_arb: clearing=%b busy=%b, expected clearing=0 busy=1", clearing, busy);
        end
    endtask

    task automatic test_reset;
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.fb_wren, bus.req_ready, busy, clearing, overrun, addr_err} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: wren=%b ready=%b busy=%b clr=%b ovr=%b err=%b, expected all 0",
                     bus.fb_wren, bus.req_ready, busy, clearing, overrun, addr_err);
        end
        checks++;
        if (bus.fb_wraddress !== '0 || bus.fb_data !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%0d data=%h, expected 0 0", bus.fb_wraddress, bus.fb_data);
        end
        frame_start = 1'b1;
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checks++;
        if (busy !== 1'b0 || bus.fb_wren !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b wren=%b, expected 0 0 while in reset", busy, bus.fb_wren);
        end
        frame_start = 1'b0;
        #2 Reset_n = 1'b1;
        tick();
        mptr = 0;
    endtask

    task automatic test_clear;
`ifdef FB_CLEAR_EN
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i), DW'(i));
        clear_color = 8'h2A;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        clear_color = 8'h55;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (bus.fb_wren !== 1'b1 || clearing !== 1'b1 || bus.req_ready !== '0 ||
                bus.fb_wraddress !== AW'(i) || bus.fb_data !== 8'h2A) begin
                errors++;
                $display("FAIL clear_write %0d: wren=%b clr=%b ready=%b addr=%0d data=%h, expected 1 1 0000 %0d 2a",
                         i, bus.fb_wren, clearing, bus.req_ready, bus.fb_wraddress, bus.fb_data, i);
            end
            if (i == DEPTH - 1) bus.req_valid = '0;
            tick();
        end
        checks++;
        if (clearing !== 1'b0 || busy !== 1'b1 || bus.fb_wren !== 1'b0) begin
            errors++;
            $display("FAIL clear_done: clr=%b busy=%b wren=%b, expected 0 1 0", clearing, busy, bus.fb_wren);
        end
`else
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || clearing !== 1'b0 || bus.fb_wren !== 1'b0) begin
            errors++;
            $display("FAIL direct_arb: busy=%b clr=%b wren=%b, expected 1 0 0", busy, clearing, bus.fb_wren);
        end
`endif
    endtask

    // Runs a list of valid masks, checking each grant and the write it produces one cycle later.
    task automatic test_round_robin;
        logic [NR-1:0] masks [7] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'h0};
        logic          ew = 1'b0;
        logic [AW-1:0] ea = '0;
        logic [DW-1:0] ed = '0;
        logic [AW-1:0] a [NR];
        logic [DW-1:0] d [NR];
        int g;
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < NR; i++) begin
                a[i] = AW'($urandom_range(0, DEPTH - 1));
                d[i] = DW'($urandom);
                set_req(i, masks[c][i], a[i], d[i]);
            end
            #1;
            g = pick(masks[c], mptr);
            checks++;
            if (bus.req_ready !== oh(g) || bus.fb_wren !== ew || (ew && (bus.fb_wraddress !== ea || bus.fb_data !== ed))) begin
                errors++;
                $display("FAIL rr cycle %0d: ready=%b wren=%b addr=%0d data=%h, expected ready=%b wren=%b addr=%0d data=%h",
                         c, bus.req_ready, bus.fb_wren, bus.fb_wraddress, bus.fb_data, oh(g), ew, ea, ed);
            end
            ew = (g >= 0);
            if (g >= 0) begin
                ea   = a[g];
                ed   = d[g];
                mptr = (g + 1) % NR;
            end
            tick();
        end
    endtask

    task automatic test_sparse;
        logic [NR-1:0] masks [4] = '{4'b1010, 4'b1010, 4'b1111, 4'b0000};
        logic          ew = 1'b0;
        logic [AW-1:0] ea = '0;
        logic [DW-1:0] ed = '0;
        int g;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < NR; i++) set_req(i, masks[c][i], AW'(c * 4 + i), DW'(8'hA0 + c * 4 + i));
            #1;
            g = pick(masks[c], mptr);
            checks++;
            if (bus.req_ready !== oh(g) || bus.fb_wren !== ew || (ew && (bus.fb_wraddress !== ea || bus.fb_data !== ed))) begin
                errors++;
                $display("FAIL sparse cycle %0d: ready=%b wren=%b addr=%0d data=%h, expected ready=%b wren=%b addr=%0d data=%h",
                         c, bus.req_ready, bus.fb_wren, bus.fb_wraddress, bus.fb_data, oh(g), ew, ea, ed);
            end
            ew = (g >= 0);
            if (g >= 0) begin
                ea   = AW'(c * 4 + g);
                ed   = DW'(8'hA0 + c * 4 + g);
                mptr = (g + 1) % NR;
            end
            tick();
        end
    endtask

    task automatic test_oob;
        bus.req_valid = '0;
        set_req(0, 1'b1, AW'(DEPTH), 8'h77);
        #1;
        checks++;
        if (bus.req_ready !== oh(pick(4'b0001, mptr))) begin
            errors++;
            $display("FAIL oob_grant: ready=%b, expected 0001", bus.req_ready);
        end
        mptr = 1;
        tick();
        bus.req_valid = '0;
        checks++;
        if (bus.fb_wren !== 1'b0 || addr_err !== 1'b1) begin
            errors++;
            $display("FAIL oob_drop: wren=%b addr_err=%b, expected 0 1", bus.fb_wren, addr_err);
        end
        tick();
        checks++;
        if (addr_err !== 1'b0) begin
            errors++;
            $display("FAIL oob_pulse: addr_err=%b, expected 0", addr_err);
        end
    endtask

    task automatic test_random;
        logic          ew = 1'b0;
        logic          ee = 1'b0;
        logic [AW-1:0] ea = '0;
        logic [DW-1:0] ed = '0;
        logic [AW-1:0] a [NR];
        logic [DW-1:0] d [NR];
        logic [NR-1:0] v;
        int g;
        for (int c = 0; c < 301; c++) begin
            checks++;
            if (bus.fb_wren !== ew || addr_err !== ee || (ew && (bus.fb_wraddress !== ea || bus.fb_data !== ed))) begin
                errors++;
                $display("FAIL random_write %0d: wren=%b err=%b addr=%0d data=%h, expected wren=%b err=%b addr=%0d data=%h",
                         c, bus.fb_wren, addr_err, bus.fb_wraddress, bus.fb_data, ew, ee, ea, ed);
            end
            v = (c == 300) ? '0 : NR'($urandom);
            for (int i = 0; i < NR; i++) begin
                a[i] = ($urandom_range(0, 5) == 0) ? AW'($urandom_range(DEPTH, DEPTH + 40))
                                                   : AW'($urandom_range(0, DEPTH - 1));
                d[i] = DW'($urandom);
                set_req(i, v[i], a[i], d[i]);
            end
            #1;
            g = pick(v, mptr);
            checks++;
            if (bus.req_ready !== oh(g)) begin
                errors++;
                $display("FAIL random_grant %0d: ready=%b, expected %b", c, bus.req_ready, oh(g));
            end
            ew = 1'b0;
            ee = 1'b0;
            if (g >= 0) begin
                mptr = (g + 1) % NR;
                if (a[g] < AW'(DEPTH)) begin
                    ew = 1'b1;
                    ea = a[g];
                    ed = d[g];
                end else begin
                    ee = 1'b1;
                end
            end
            tick();
        end
    endtask

    task automatic test_overrun;
        bus.req_valid = '0;
        set_req(0, 1'b1, AW'(5), 8'hC3);
        tick();
        mptr = 1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i), DW'(i));
        frame_start = 1'b1;
        clear_color = 8'h3C;
        #1;
        checks++;
        if (bus.req_ready !== '0 || bus.fb_wren !== 1'b1 || bus.fb_wraddress !== AW'(5) || bus.fb_data !== 8'hC3) begin
            errors++;
            $display("FAIL overrun_cycle: ready=%b wren=%b addr=%0d data=%h, expected 0000 1 5 c3",
                     bus.req_ready, bus.fb_wren, bus.fb_wraddress, bus.fb_data);
        end
        tick();
        frame_start   = 1'b0;
        bus.req_valid = '0;
        checks++;
        if (overrun !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: overrun=%b busy=%b, expected 1 1", overrun, busy);
        end
`ifdef FB_CLEAR_EN
        checks++;
        if (bus.fb_wren !== 1'b1 || bus.fb_wraddress !== '0 || bus.fb_data !== 8'h3C || clearing !== 1'b1) begin
            errors++;
            $display("FAIL overrun_restart: wren=%b addr=%0d data=%h clr=%b, expected 1 0 3c 1",
                     bus.fb_wren, bus.fb_wraddress, bus.fb_data, clearing);
        end
        for (int n = 0; n < 40 && !(bus.fb_wren && bus.fb_wraddress == AW'(9)); n++) tick();
        checks++;
        if (bus.fb_wraddress !== AW'(9)) begin
            errors++;
            $display("FAIL clear_reach9: addr=%0d, expected 9", bus.fb_wraddress);
        end
        frame_start = 1'b1;
        clear_color = 8'h11;
        tick();
        frame_start = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL mid_clear_overrun: overrun=%b, expected 1", overrun);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (bus.fb_wren !== 1'b1 || bus.fb_wraddress !== AW'(i) || bus.fb_data !== 8'h11) begin
                errors++;
                $display("FAIL reclear %0d: wren=%b addr=%0d data=%h, expected 1 %0d 11",
                         i, bus.fb_wren, bus.fb_wraddress, bus.fb_data, i);
            end
            tick();
        end
        checks++;
        if (clearing !== 1'b0 || overrun !== 1'b0 || bus.fb_wren !== 1'b0) begin
            errors++;
            $display("FAIL reclear_done: clr=%b overrun=%b wren=%b, expected 0 0 0", clearing, overrun, bus.fb_wren);
        end
`else
        checks++;
        if (bus.fb_wren !== 1'b0 || clearing !== 1'b0) begin
            errors++;
            $display("FAIL overrun_nogrant: wren=%b clr=%b, expected 0 0", bus.fb_wren, clearing);
        end
        tick();
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_once: overrun=%b, expected 0", overrun);
        end
`endif
    endtask

    task automatic test_end;
        bus.req_valid = '0;
        set_req(2, 1'b1, AW'(7), 8'h99);
        draw_end = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== '0) begin
            errors++;
            $display("FAIL end_nogrant: ready=%b, expected 0000", bus.req_ready);
        end
        tick();
        draw_end = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || bus.fb_wren !== 1'b0 || bus.req_ready !== '0) begin
            errors++;
            $display("FAIL end_idle: busy=%b wren=%b ready=%b, expected 0 0 0000", busy, bus.fb_wren, bus.req_ready);
        end
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_async_reset;
        int g;
        enter_arb();
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 3), DW'(8'h40 + i));
        #1;
        g = pick(4'hF, mptr);
        tick();
        checks++;
        if (bus.fb_wren !== 1'b1 || bus.fb_wraddress !== AW'(g + 3) || bus.req_ready === '0) begin
            errors++;
            $display("FAIL pre_reset: wren=%b addr=%0d ready=%b, expected 1 %0d nonzero",
                     bus.fb_wren, bus.fb_wraddress, bus.req_ready, g + 3);
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if (bus.fb_wren !== 1'b0 || bus.req_ready !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: wren=%b ready=%b busy=%b, expected 0 0000 0", bus.fb_wren, bus.req_ready, busy);
        end
        bus.req_valid = '0;
        #2 Reset_n = 1'b1;
        mptr = 0;
        tick();
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        test_reset();
        test_clear();
        test_round_robin();
        test_sparse();
        test_oob();
        test_random();
        test_overrun();
`ifdef FB_CLEAR_EN
        test_end();
`else
        test_end();
`endif
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Sequences and shares the single write port of the 8-bit-per-pixel frame buffer (19-bit address) among NUM_REQ drawing requesters (sprite drawers, HUD, slash trail).
- Per frame: on frame_start it optionally clears the buffer to clear_color, then round-robin arbitrates pixel writes until draw_end.
- Sits between the drawing engines and the frame buffer's wraddress/data/wren inputs, in the 50 MHz Clk domain.

Parameters:
- NUM_REQ, 4, number of write requesters (2..8).
- FB_DEPTH, 307200, pixel count (640x480); valid addresses are 0..FB_DEPTH-1.
- ADDR_W, 19, frame buffer address width.
- DATA_W, 8, pixel width.

Ports:
- Clk  in  1  system clock (50 MHz).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  single-cycle pulse; begins a new frame.
- draw_end  in  1  single-cycle pulse; ends the arbitration phase.
- clear_color  in  DATA_W  background value used during the clear phase.
- req_valid  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_data  in  NUM_REQ*DATA_W  packed pixel data.
- req_ready  out  NUM_REQ  one-hot grant.
- fb_wraddress  out  ADDR_W  frame buffer write address.
- fb_data  out  DATA_W  frame buffer write data.
- fb_wren  out  1  frame buffer write enable.
- busy  out  1  high in CLEAR or ARB.
- clearing  out  1  high in CLEAR.
- overrun  out  1  one-cycle pulse when frame_start arrives while not IDLE.
- addr_err  out  1  one-cycle pulse when an accepted write is out of range and dropped.

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - State goes to IDLE; round-robin pointer goes to 0; clear counter goes to 0.
  - All outputs are 0: fb_wraddress, fb_data, fb_wren, req_ready, busy, clearing, overrun, addr_err.
  - Reset asserted mid-clear or mid-arbitration aborts the operation immediately; no further fb_wren.
- States are IDLE, CLEAR and ARB.
- IDLE:
  - req_ready=0, fb_wren=0.
  - frame_start -> CLEAR (or ARB when FB_CLEAR_EN is undefined).
- CLEAR:
  - One write per cycle, fb_wraddress = counter, fb_data = clear_color sampled at entry, fb_wren=1.
  - The counter runs 0..FB_DEPTH-1, so the phase lasts exactly FB_DEPTH cycles; then -> ARB with the counter reset to 0.
  - req_ready=0 throughout.
  - draw_end is ignored.
- ARB:
  - req_ready is combinational: one-hot to the first valid requester at or after the pointer, wrapping NUM_REQ-1 -> 0.
  - Transfer occurs when req_valid[i] & req_ready[i]. The pointer then moves to i+1 mod NUM_REQ.
  - Latency is 1 cycle: the next cycle has fb_wren=1 with the registered addr/data. Sustained throughput is one write per cycle.
  - Accepted address >= FB_DEPTH: fb_wren stays 0 and addr_err pulses in the write cycle.
  - No valid requests: req_ready=0, fb_wren=0, pointer unchanged.
  - draw_end -> IDLE. No grant is issued in the draw_end cycle. A write accepted in the previous cycle still completes.
- frame_start while in CLEAR or ARB:
  - overrun pulses and the state restarts at CLEAR with address 0 (ARB if FB_CLEAR_EN is undefined).
  - No grant in that cycle; an in-flight write completes.
- frame_start and draw_end in the same cycle: frame_start wins.
- busy = (state != IDLE); clearing = (state == CLEAR); both are registered.

Optional Feature:
- Macro: FB_CLEAR_EN.
- Defined: CLEAR phase as described above.
- Undefined:
  - No CLEAR state and no counter.
  - frame_start goes directly to ARB; clearing is tied to 0; clear_color is unused.
  - The previous frame's pixels persist.

Test Plan:
- Reset/clear:
  - Stimulus: FB_DEPTH=16, FB_CLEAR_EN defined, reset, then frame_start with clear_color=8'h2A.
  - Response: 16 consecutive writes to addresses 0..15 with data 8'h2A; clearing high for 16 cycles; req_ready=0 throughout; then ARB.
- Round-robin fairness:
  - Stimulus: NUM_REQ=4, all req_valid=1 continuously in ARB.
  - Response: grants 0,1,2,3,0,1 on consecutive cycles; fb_wren=1 every cycle, one cycle behind each grant, with the matching addr/data.
- Sparse requests and pointer wrap:
  - Stimulus: only requesters 3 and 1 valid, pointer at 2.
  - Response: grant goes to 3, then 1; pointer ends at 2.
- Out-of-range drop:
  - Stimulus: requester 0 writes address 16 with FB_DEPTH=16.
  - Response: req_ready[0]=1; next cycle fb_wren=0 and addr_err=1 for one cycle.
- Overrun and restart:
  - Stimulus: frame_start during CLEAR at counter=9.
  - Response: overrun pulses; next write goes to address 0; 16 clear writes follow.
- End and async reset:
  - Stimulus: draw_end in ARB with requester 2 valid.
  - Response: no grant that cycle; busy=0 next cycle.
  - Stimulus: Reset_n low mid-ARB.
  - Response: fb_wren and req_ready drop to 0 without waiting for a Clk edge.
